// File: rtl/timer_ctrl.sv
// Stopwatch countdown sequencing controller: turns synchronized button levels
// into timer control strobes, a one-second tick, and a timed alarm.
module timer_ctrl #(
  parameter int TICK_DIV   = 10_000_000,
  parameter int ALARM_SECS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_add,
  input  logic       btn_clear,
  input  logic       time_up,
  output logic       enable_in,
  output logic       lap,
  output logic       enable_dec,
  output logic       clk_div,
  output logic       clear,
  output logic       alarm,
  output logic [2:0] state
);

  // state | meaning
  // IDLE  | timer held cleared, waiting for start
  // SET   | user adds 30 s increments
  // RUN   | counting down, one clk_div per second
  // PAUSE | countdown frozen, sub-second fraction kept
  // DONE  | alarm asserted for ALARM_SECS seconds
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ALARM_SECS + 1);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] A_LAST = AW'(ALARM_SECS - 1);

  state_t        cur, nxt;
  logic          prev_start, prev_add, prev_clear;
  logic          start_e, add_e, clear_e;
  logic [PW-1:0] pcnt;
  logic [AW-1:0] acnt;
  logic          counting, tick;

  assign start_e  = btn_start & ~prev_start;
  assign add_e    = btn_add   & ~prev_add;
  assign clear_e  = btn_clear & ~prev_clear;
  assign counting = (cur == S_RUN) || (cur == S_DONE);
  assign tick     = counting && (pcnt == P_LAST);

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:  if (start_e) nxt = S_SET;
      S_SET: begin
        if (clear_e)      nxt = S_IDLE;
        else if (start_e) nxt = S_RUN;
      end
      S_RUN: begin
        if (time_up)      nxt = S_DONE;
        else if (clear_e) nxt = S_IDLE;
        else if (start_e) nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (clear_e)      nxt = S_IDLE;
        else if (start_e) nxt = S_RUN;
      end
      S_DONE: begin
        if (start_e || add_e || clear_e)  nxt = S_IDLE;
        else if (tick && acnt == A_LAST)  nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur        <= S_IDLE;
      prev_start <= 1'b1;
      prev_add   <= 1'b1;
      prev_clear <= 1'b1;
    end else begin
      cur        <= nxt;
      prev_start <= btn_start;
      prev_add   <= btn_add;
      prev_clear <= btn_clear;
    end
  end

  // Restarting at DONE entry makes the alarm last exactly ALARM_SECS*TICK_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (nxt == S_DONE && cur != S_DONE) begin
      pcnt <= '0;
    end else if (counting) begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
    end else if (cur != S_PAUSE) begin
      pcnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acnt <= '0;
    end else if (cur != S_DONE) begin
      acnt <= '0;
    end else if (tick) begin
      acnt <= acnt + AW'(1);
    end
  end

  assign enable_in  = (cur == S_SET);
  assign lap        = (cur == S_SET) & add_e & ~start_e & ~clear_e;
  assign enable_dec = (cur == S_RUN);
  assign clk_div    = (cur == S_RUN) & tick;
  assign clear      = (cur == S_IDLE);
  assign alarm      = (cur == S_DONE);
  assign state      = cur;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with TICK_DIV=4 and ALARM_SECS=3.
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_start, btn_add, btn_clear, time_up;
  logic       enable_in, lap, enable_dec, clk_div, clear, alarm;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  timer_ctrl #(.TICK_DIV(4), .ALARM_SECS(3)) dut (
    .clk(clk), .rst(rst),
    .btn_start(btn_start), .btn_add(btn_add), .btn_clear(btn_clear),
    .time_up(time_up),
    .enable_in(enable_in), .lap(lap), .enable_dec(enable_dec),
    .clk_div(clk_div), .clear(clear), .alarm(alarm), .state(state)
  );

  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge; inputs change and outputs are sampled here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start press followed by one release cycle.
  task automatic press_start();
    btn_start = 1'b1;
    cyc();
    btn_start = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    btn_start = 1'b1; btn_add = 1'b1; btn_clear = 1'b1; time_up = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || clear !== 1'b1 || clk_div !== 1'b0 || lap !== 1'b0 ||
        alarm !== 1'b0 || enable_in !== 1'b0 || enable_dec !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: state=%0d clear=%b clk_div=%b lap=%b alarm=%b en_in=%b en_dec=%b, want 0/1/0/0/0/0/0",
               state, clear, clk_div, lap, alarm, enable_in, enable_dec);
    end
    cyc(); cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (state !== 3'd0 || clear !== 1'b1) begin
        errors++;
        $display("FAIL reset_held_buttons cycle %0d: state=%0d clear=%b, want 0/1", i, state, clear);
      end
    end
    btn_start = 1'b0; btn_add = 1'b0; btn_clear = 1'b0;
    cyc();
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: state=%0d, want 0", state);
    end
  endtask

  task automatic test_set_run();
    int lap_cycles;
    press_start();
    checks++;
    if (state !== 3'd1 || enable_in !== 1'b1 || clear !== 1'b0) begin
      errors++;
      $display("FAIL enter_set: state=%0d en_in=%b clear=%b, want 1/1/0", state, enable_in, clear);
    end
    lap_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      btn_add = 1'b1;
      #1;
      if (lap === 1'b1) lap_cycles++;
      cyc();
      btn_add = 1'b0;
      #1;
      checks++;
      if (lap !== 1'b0 || enable_in !== 1'b1 || state !== 3'd1) begin
        errors++;
        $display("FAIL lap_width add %0d: lap=%b en_in=%b state=%0d, want 0/1/1", i, lap, enable_in, state);
      end
      cyc();
    end
    checks++;
    if (lap_cycles !== 3) begin
      errors++;
      $display("FAIL lap_count: got %0d pulses, want 3", lap_cycles);
    end
    btn_start = 1'b1;
    cyc();
    btn_start = 1'b0;
    checks++;
    if (state !== 3'd2 || enable_dec !== 1'b1 || enable_in !== 1'b0) begin
      errors++;
      $display("FAIL enter_run: state=%0d en_dec=%b en_in=%b, want 2/1/0", state, enable_dec, enable_in);
    end
    // Entry cycle is index 0; pcnt reaches 3 at index 3, 7, 11.
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (clk_div !== ((i % 4) == 3)) begin
        errors++;
        $display("FAIL clk_div_cadence index %0d: clk_div=%b, want %b", i, clk_div, (i % 4) == 3);
      end
      if (i < 11) cyc();
    end
  endtask

  task automatic test_pause();
    // Currently in the tick cycle (pcnt=3); two cycles later pcnt=1.
    cyc(); cyc();
    btn_start = 1'b1;
    cyc();
    btn_start = 1'b0;
    checks++;
    if (state !== 3'd3 || enable_dec !== 1'b0) begin
      errors++;
      $display("FAIL enter_pause: state=%0d en_dec=%b, want 3/0", state, enable_dec);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (clk_div !== 1'b0 || state !== 3'd3) begin
        errors++;
        $display("FAIL pause_hold cycle %0d: clk_div=%b state=%0d, want 0/3", i, clk_div, state);
      end
      cyc();
    end
    btn_start = 1'b1;
    cyc();
    btn_start = 1'b0;
    checks++;
    if (state !== 3'd2 || clk_div !== 1'b0) begin
      errors++;
      $display("FAIL resume_entry: state=%0d clk_div=%b, want 2/0", state, clk_div);
    end
    cyc();
    checks++;
    if (clk_div !== 1'b1) begin
      errors++;
      $display("FAIL resume_first_tick: clk_div=%b, want 1", clk_div);
    end
  endtask

  task automatic test_expiry();
    int alarm_cycles;
    time_up = 1'b1;
    cyc();
    time_up = 1'b0;
    checks++;
    if (state !== 3'd4 || alarm !== 1'b1 || enable_dec !== 1'b0) begin
      errors++;
      $display("FAIL enter_done: state=%0d alarm=%b en_dec=%b, want 4/1/0", state, alarm, enable_dec);
    end
    alarm_cycles = 0;
    while (alarm === 1'b1 && alarm_cycles < 50) begin
      alarm_cycles++;
      cyc();
    end
    checks++;
    if (alarm_cycles !== 12) begin
      errors++;
      $display("FAIL alarm_length: got %0d cycles, want 12", alarm_cycles);
    end
    checks++;
    if (state !== 3'd0 || clear !== 1'b1) begin
      errors++;
      $display("FAIL alarm_exit: state=%0d clear=%b, want 0/1", state, clear);
    end
    press_start();
    press_start();
    time_up = 1'b1;
    cyc();
    time_up = 1'b0;
    cyc();
    btn_add = 1'b1;
    cyc();
    btn_add = 1'b0;
    checks++;
    if (state !== 3'd0 || alarm !== 1'b0 || clear !== 1'b1) begin
      errors++;
      $display("FAIL done_add_exit: state=%0d alarm=%b clear=%b, want 0/0/1", state, alarm, clear);
    end
    cyc();
    btn_add = 1'b1;
    cyc();
    btn_add = 1'b0;
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL idle_ignores_add: state=%0d, want 0", state);
    end
    cyc();
  endtask

  task automatic test_priority();
    press_start();
    btn_start = 1'b1; btn_add = 1'b1; btn_clear = 1'b1;
    #1;
    checks++;
    if (lap !== 1'b0) begin
      errors++;
      $display("FAIL prio_set_lap: lap=%b, want 0", lap);
    end
    cyc();
    btn_start = 1'b0; btn_add = 1'b0; btn_clear = 1'b0;
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL prio_set_clear: state=%0d, want 0", state);
    end
    cyc();
    press_start();
    press_start();
    btn_add = 1'b1;
    cyc();
    btn_add = 1'b0;
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL run_ignores_add: state=%0d, want 2", state);
    end
    cyc();
    time_up = 1'b1; btn_start = 1'b1;
    cyc();
    time_up = 1'b0; btn_start = 1'b0;
    checks++;
    if (state !== 3'd4) begin
      errors++;
      $display("FAIL prio_timeup_over_start: state=%0d, want 4", state);
    end
    cyc();
    btn_clear = 1'b1;
    cyc();
    btn_clear = 1'b0;
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL done_clear_exit: state=%0d, want 0", state);
    end
    cyc();
  endtask

  task automatic test_async_reset();
    press_start();
    press_start();
    cyc();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || clear !== 1'b1 || enable_dec !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: state=%0d clear=%b en_dec=%b, want 0/1/0", state, clear, enable_dec);
    end
    cyc();
    rst = 1'b0;
    cyc();
    press_start();
    btn_start = 1'b1;
    cyc();
    btn_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (state !== 3'd2 || clk_div !== (i == 3)) begin
        errors++;
        $display("FAIL post_reset_cadence index %0d: state=%0d clk_div=%b, want 2/%b", i, state, clk_div, i == 3);
      end
      if (i < 3) cyc();
    end
  endtask

  initial begin
    test_reset();
    test_set_run();
    test_pause();
    test_expiry();
    test_priority();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
